// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: generates the fetch PC, buffers fetched {pc, instr}
// pairs in a small FIFO for decode, and handles redirects and ECALL halt.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0033
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_busy,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_fpc;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  entry_t          r_fifo [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_req;
  logic            w_gnt;
  logic            w_deq;
  logic            w_ecall;
  logic [XLEN-1:0] w_target;
  entry_t          w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Redirect gates the request combinationally; stall/mem_busy never reach imem_req.
  assign w_req    = (r_state == S_RUN) & ~w_full & ~redirect;
  assign w_gnt    = w_req & ~mem_busy;
  assign w_deq    = ~w_empty & ~stall & ~redirect;
  assign w_ecall  = (imem_rdata[6:2] == 5'b11100) && (imem_rdata[14:12] == 3'b000);
  assign w_target = redirect_pc & 32'hFFFF_FFFC;
  assign w_head   = r_fifo[r_rptr];

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: redirect always restarts fetch, even out of HALT
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = S_RUN;
    end else if (w_gnt && w_ecall) begin
      w_state_nxt = S_HALT;
    end
  end

  // Outputs: head entry, or NOP/0 bubble when empty
  always_comb begin
    imem_req  = w_req;
    imem_addr = r_fpc;
    if_valid  = ~w_empty;
    if_pc     = '0;
    if_instr  = NOP;
    halted    = (r_state == S_HALT) & w_empty;
    if (!w_empty) begin
      if_pc    = w_head.pc;
      if_instr = w_head.instr;
    end
  end

  // Fetch PC, pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_fpc   <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_fpc   <= w_target;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_gnt) begin
        r_fpc  <= r_fpc + 32'd4;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_deq) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_gnt, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; validity lives in r_count
  always_ff @(posedge CLK) begin
    if (w_gnt) begin
      r_fifo[r_wptr] <= '{pc: r_fpc, instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a combinational instruction memory model.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] NOP_W = 32'h0000_0033;

  logic        CLK;
  logic        RST;
  logic        mem_busy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;

  logic        ecall_en;
  logic [31:0] ecall_addr;
  int          checks;
  int          failures;

  fetch_prefetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000),
    .NOP(NOP_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .mem_busy(mem_busy),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: ADDI-style word tagged with address bits, optional ECALL at one address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[26:2], 7'b0010011};
  endfunction

  always_comb begin
    if (ecall_en && imem_addr == ecall_addr) imem_rdata = 32'h0000_0073;
    else imem_rdata = word_at(imem_addr);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; mem_busy = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0; mem_busy = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL reset_req got %b/%h exp 1/00000000", imem_req, imem_addr);
    end
    checks++;
    if ({if_valid, if_pc, if_instr, halted} !== {1'b0, 32'h0, NOP_W, 1'b0}) begin
      failures++; $display("FAIL reset_if got v=%b pc=%h ins=%h h=%b", if_valid, if_pc, if_instr, halted);
    end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_straight();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
        failures++; $display("FAIL straight_addr c%0d got %b/%h exp 1/%h", i, imem_req, imem_addr, 4 * i);
      end
      if (i == 0) begin
        checks++;
        if (if_valid !== 1'b0) begin
          failures++; $display("FAIL straight_empty got %b exp 0", if_valid);
        end
      end else begin
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(4 * (i - 1)), word_at(32'(4 * (i - 1)))}) begin
          failures++; $display("FAIL straight_if c%0d got %b/%h/%h exp pc %h", i, if_valid, if_pc, if_instr, 4 * (i - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({imem_req, if_valid, if_pc} !== {1'b0, 1'b1, 32'h0}) begin
        failures++; $display("FAIL fill_full got req=%b v=%b pc=%h exp 0/1/0", imem_req, if_valid, if_pc);
      end
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, exp_pc[i], word_at(exp_pc[i])}) begin
        failures++; $display("FAIL fill_drain d%0d got %b/%h/%h exp pc %h", i, if_valid, if_pc, if_instr, exp_pc[i]);
      end
      if (i == 1) begin
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
          failures++; $display("FAIL fill_resume got %b/%h exp 1/00000010", imem_req, imem_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC};
    logic        exp_v    [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_pc   [7] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h8, 32'hC};
    logic [31:0] exp_ins;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      mem_busy = (c == 2 || c == 3);
      #1;
      if (c < 6) begin
        checks++;
        if (imem_addr !== exp_addr[c]) begin
          failures++; $display("FAIL busy_addr c%0d got %h exp %h", c, imem_addr, exp_addr[c]);
        end
      end
      exp_ins = exp_v[c] ? word_at(exp_pc[c]) : NOP_W;
      checks++;
      if ({if_valid, if_pc, if_instr} !== {exp_v[c], exp_pc[c], exp_ins}) begin
        failures++; $display("FAIL busy_if c%0d got %b/%h/%h exp %b/%h/%h", c, if_valid, if_pc, if_instr, exp_v[c], exp_pc[c], exp_ins);
      end
      tick();
    end
    mem_busy = 1'b0;
  endtask

  task automatic test_redirect_full();
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL redir_gate got %b exp 0", imem_req);
    end
    tick();
    redirect = 1'b0; stall = 1'b0;
    #1;
    checks++;
    if ({if_valid, if_instr, imem_req, imem_addr} !== {1'b0, NOP_W, 1'b1, 32'h100}) begin
      failures++; $display("FAIL redir_n1 got v=%b ins=%h req=%b addr=%h exp 0/%h/1/00000100", if_valid, if_instr, imem_req, imem_addr, NOP_W);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'(32'h100 + 4 * i), word_at(32'(32'h100 + 4 * i))}) begin
        failures++; $display("FAIL redir_target t%0d got %b/%h/%h exp pc %h", i, if_valid, if_pc, if_instr, 32'h100 + 4 * i);
      end
      tick();
    end
  endtask

  task automatic test_ecall();
    do_reset();
    ecall_en = 1'b1; ecall_addr = 32'h8;
    tick(); tick(); tick();
    #1;
    checks++;
    if ({imem_req, if_valid, if_pc, if_instr, halted} !== {1'b0, 1'b1, 32'h8, 32'h73, 1'b0}) begin
      failures++; $display("FAIL ecall_head got req=%b v=%b pc=%h ins=%h h=%b", imem_req, if_valid, if_pc, if_instr, halted);
    end
    tick();
    #1;
    checks++;
    if ({halted, if_valid, imem_req} !== 3'b100) begin
      failures++; $display("FAIL ecall_halted got h=%b v=%b req=%b exp 1/0/0", halted, if_valid, imem_req);
    end
    tick();
    redirect = 1'b1; redirect_pc = 32'h20;
    #1;
    checks++;
    if ({halted, imem_req} !== 2'b10) begin
      failures++; $display("FAIL ecall_hold got h=%b req=%b exp 1/0", halted, imem_req);
    end
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
      failures++; $display("FAIL ecall_resume got h=%b req=%b addr=%h exp 0/1/00000020", halted, imem_req, imem_addr);
    end
    tick();
    #1;
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h20}) begin
      failures++; $display("FAIL ecall_target got %b/%h exp 1/00000020", if_valid, if_pc);
    end
    ecall_en = 1'b0;
    tick();
  endtask

  task automatic test_wrap_reset();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL wrap_first got %b/%h exp 1/fffffffc", imem_req, imem_addr);
    end
    tick();
    #1;
    checks++;
    if ({imem_addr, if_pc, if_instr} !== {32'h0, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)}) begin
      failures++; $display("FAIL wrap_zero got addr=%h pc=%h ins=%h exp 0/fffffffc", imem_addr, if_pc, if_instr);
    end
    tick();
    stall = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h0, 32'hC}) begin
      failures++; $display("FAIL wrap_buffered got v=%b pc=%h addr=%h exp 1/0/c", if_valid, if_pc, imem_addr);
    end
    RST = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    checks++;
    if ({if_valid, if_instr, imem_req, imem_addr} !== {1'b0, NOP_W, 1'b1, 32'h0}) begin
      failures++; $display("FAIL midreset got v=%b ins=%h req=%b addr=%h exp 0/%h/1/0", if_valid, if_instr, imem_req, imem_addr, NOP_W);
    end
    stall = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; failures = 0;
    ecall_en = 1'b0; ecall_addr = 32'hFFFF_FFF0;
    RST = 1'b0; mem_busy = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_straight();
    test_fill_stall();
    test_contention();
    test_redirect_full();
    test_ecall();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It generates the fetch PC and requests instruction words from the shared single-port memory whenever the data side is idle. Fetched {PC, instruction} pairs are buffered in a small FIFO, and the head entry is presented to decode. It also absorbs taken-branch/jump redirects from decode and stops fetching once an ECALL has been fetched. This replaces the slow-clock time-multiplexing of instruction and data accesses.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0033, instruction word driven when no valid entry (ADD x0,x0,x0)

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- mem_busy  in  1  data port (EX/MEM load/store) owns memory this cycle; fetch denied
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word aligned)
- imem_rdata  in  32  memory read data, combinational, valid in the same cycle as a granted request
- redirect  in  1  decode-stage taken branch/JAL/JALR
- redirect_pc  in  32  target PC; bits [1:0] ignored (treated as 0)
- stall  in  1  hazard-unit stall; IF/ID holds, head not consumed
- if_valid  out  1  head entry valid
- if_pc  out  32  head entry PC
- if_instr  out  32  head entry instruction
- halted  out  1  ECALL fetched and all entries consumed

## Operation
- State: fetch PC register fpc, FIFO (DEPTH × 64 bits {pc, instr}), read/write pointers (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits), FSM {RUN, HALT}.
- imem_req = (state==RUN) & (count != DEPTH) & ~redirect; imem_addr = fpc.
- Grant: gnt = imem_req & ~mem_busy. On gnt, enqueue {fpc, imem_rdata} and fpc <= fpc + 4, wrapping 32'hFFFF_FFFC -> 0.
- Dequeue: deq = if_valid & ~stall & ~redirect. It pops the head; decode captures if_pc/if_instr on that same edge.
- Outputs: if_valid = (count != 0). When if_valid=0: if_instr = NOP and if_pc = 0.
- ECALL detect on the enqueued word: imem_rdata[6:2]==5'b11100 and [14:12]==3'b000. On gnt with ECALL, the word is enqueued and state <= HALT. In HALT, imem_req=0 and the FIFO drains normally.
- halted = (state==HALT) & (count==0).
- Redirect has highest priority:
  - FIFO cleared (count, pointers to 0)
  - fpc <= {redirect_pc[31:2], 2'b00}
  - state <= RUN, even from HALT (an ECALL fetched in a branch shadow is discarded)
  - no enqueue or dequeue in a redirect cycle
- Simultaneous gnt and deq: count unchanged; both pointers advance.
- count never exceeds DEPTH. Enqueue when full is impossible because imem_req is gated. Dequeue when empty is impossible because if_valid is gated.
- mem_busy only blocks grants; it never affects dequeue.
- Reset (RST=0 at an edge): fpc <= RESET_PC, pointers and count 0, state RUN. This applies mid-operation too; all buffered entries are discarded.

## Timing
- Reset output values: imem_req=1, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP, halted=0. These hold throughout reset because imem_req depends only on state and count.
- Fetch-to-decode latency: a word granted in cycle N appears at if_* in cycle N+1 when the FIFO was empty.
- Throughput: one fetch per cycle while mem_busy=0 and not full; one dequeue per cycle while stall=0.
- Redirect asserted in cycle N: if_valid=0 in cycle N+1, and imem_addr=redirect target in N+1. The first target instruction is visible in N+2 if mem_busy=0 in N+1.
- ECALL granted in cycle N: imem_req=0 from N+1. halted rises the cycle after the ECALL entry is dequeued.
- No combinational path from stall or mem_busy to imem_req. redirect gates imem_req combinationally.

## Test plan
- Straight-line fetch: release reset with mem_busy=0, stall=0 and memory words at 0,4,8,12 → imem_addr 0,4,8,12 in consecutive cycles; if_pc 0,4,8 in cycles 1,2,3 with matching if_instr; count stays ≤1.
- Fill under stall: stall=1 from cycle 0 → four grants, then imem_req=0 with count=4 and if_pc=0 held. Release stall → entries 0,4,8,C dequeue in order, and fetching resumes at 0x10.
- Data-port contention: mem_busy=1 in cycles 2–3 → imem_addr holds 0x8 for three cycles, no enqueue during busy cycles, no PC skipped or duplicated.
- Redirect with full FIFO: redirect=1, redirect_pc=0x103 → next cycle if_valid=0 and imem_addr=0x100. The cycle after that, if_pc=0x100; stale entries never appear.
- ECALL halt: word 0x0000_0073 at address 0x8 → imem_req drops after the grant at 0x8; if_* delivers 0,4,8; halted=1 one cycle after 0x8 is consumed. A redirect to 0x20 in HALT → halted=0 and fetch resumes at 0x20.
- Wrap and reset: redirect_pc=0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0. Asserting RST=0 mid-stream with 3 entries buffered → next cycle if_valid=0 and imem_addr=RESET_PC.
